conv_tile_sched: RTL

Top-level tile scheduler for the convolution accelerator. On one conv_start it walks every tile coordinate (n, m, row, col) of an N x M x R x C layer and drives conv_tile with one start pulse per tile. It waits for each conv_tile_done, then advances the coordinates and signals conv_done after the last tile. This block replaces the ad-hoc start/done glue (sig_delay, counter, gen_tile_cord) around conv_tile with one FSM.

---
 rtl/conv_tile_sched_if.sv | 35 +++
 rtl/conv_tile_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/conv_tile_sched_if.sv
// Handshake bundle between the layer-level tile scheduler and its controller / conv_tile.
//   conv_start, conv_abort  : layer start / cancel requests into the scheduler
//   conv_tile_done          : per-tile completion pulse from conv_tile
//   conv_tile_start         : per-tile start pulse to conv_tile
//   tile_base_n/m/row/col   : coordinates of the current tile
//   tile_idx                : linear index of the current tile
//   conv_busy, conv_done    : layer status
// The master modport is the scheduler side. The slave modport is the controller/conv_tile side.
interface conv_tile_sched_if #(
   parameter int unsigned AW = 32
);
   logic          conv_start;
   logic          conv_abort;
   logic          conv_tile_done;
   logic          conv_tile_start;
   logic [AW-1:0] tile_base_n;
   logic [AW-1:0] tile_base_m;
   logic [AW-1:0] tile_base_row;
   logic [AW-1:0] tile_base_col;
   logic [AW-1:0] tile_idx;
   logic          conv_busy;
   logic          conv_done;

   modport master (
      input  conv_start, conv_abort, conv_tile_done,
      output conv_tile_start, tile_base_n, tile_base_m, tile_base_row, tile_base_col,
             tile_idx, conv_busy, conv_done
   );

   modport slave (
      output conv_start, conv_abort, conv_tile_done,
      input  conv_tile_start, tile_base_n, tile_base_m, tile_base_row, tile_base_col,
             tile_idx, conv_busy, conv_done
   );
endinterface

// File: rtl/conv_tile_sched.sv
// Layer tile scheduler: on conv_start, walks every (n, m, row, col) tile of an N x M x R x C
// layer. It issues one conv_tile_start per tile and waits for conv_tile_done before it
// advances. conv_done pulses after the last tile.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  conv_tile_sched_if.master (start/abort/tile_done in; tile_start, bases, idx,
//        busy and done out). All outputs are registered.
// Loop order, innermost first: m, col, row, n.
module conv_tile_sched #(
   parameter int unsigned AW = 32,
   parameter int unsigned N  = 128,
   parameter int unsigned M  = 256,
   parameter int unsigned R  = 128,
   parameter int unsigned C  = 128,
   parameter int unsigned Tn = 16,
   parameter int unsigned Tm = 16,
   parameter int unsigned Tr = 64,
   parameter int unsigned Tc = 16,
   parameter int unsigned K  = 3,
   parameter int unsigned S  = 1
) (
   input  logic                clk,
   input  logic                rst,
   conv_tile_sched_if.master   bus
);
   localparam int unsigned TRK      = (Tr + S - K) / S;
   localparam int unsigned TCK      = (Tc + S - K) / S;
   localparam int unsigned RK       = (R + S - K) / S;
   localparam int unsigned CK       = (C + S - K) / S;
   localparam int unsigned NT       = (N + Tn - 1) / Tn;
   localparam int unsigned MT       = (M + Tm - 1) / Tm;
   localparam int unsigned RT       = (RK + TRK - 1) / TRK;
   localparam int unsigned CT       = (CK + TCK - 1) / TCK;
   localparam int unsigned TILE_NUM = NT * MT * RT * CT;

   localparam logic [AW-1:0] TileLast = AW'(TILE_NUM - 1);
   localparam logic [AW-1:0] MtLast   = AW'(MT - 1);
   localparam logic [AW-1:0] CtLast   = AW'(CT - 1);
   localparam logic [AW-1:0] RtLast   = AW'(RT - 1);
   localparam logic [AW-1:0] StepM    = AW'(Tm);
   localparam logic [AW-1:0] StepN    = AW'(Tn);
   localparam logic [AW-1:0] StepRow  = AW'(TRK * S);
   localparam logic [AW-1:0] StepCol  = AW'(TCK * S);
   localparam logic [AW-1:0] One      = AW'(1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] n_q, n_d, m_q, m_d, row_q, row_d, col_q, col_d, idx_q, idx_d;
   // Per-dimension tile counters decide the wraps. This avoids comparing bases that
   // could overflow AW.
   logic [AW-1:0] cnt_m_q, cnt_m_d, cnt_col_q, cnt_col_d, cnt_row_q, cnt_row_d;
   logic          start_q, start_d, busy_q, busy_d, done_q, done_d;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      m_d       = m_q;
      row_d     = row_q;
      col_d     = col_q;
      idx_d     = idx_q;
      cnt_m_d   = cnt_m_q;
      cnt_col_d = cnt_col_q;
      cnt_row_d = cnt_row_q;
      unique case (state_q)
         StIdle: begin
            if (bus.conv_start) begin
               state_d = StStart;
               {n_d, m_d, row_d, col_d, idx_d} = '0;
               {cnt_m_d, cnt_col_d, cnt_row_d} = '0;
            end
         end
         StStart: begin
            // A tile_done arriving alongside the start pulse belongs to no tile and is ignored.
            state_d = StWait;
         end
         StWait: begin
            if (bus.conv_tile_done) begin
               if (idx_q == TileLast) begin
                  state_d = StDone;
               end else begin
                  state_d = StStart;
                  idx_d   = idx_q + One;
                  if (cnt_m_q == MtLast) begin
                     cnt_m_d = '0;
                     m_d     = '0;
                     if (cnt_col_q == CtLast) begin
                        cnt_col_d = '0;
                        col_d     = '0;
                        if (cnt_row_q == RtLast) begin
                           cnt_row_d = '0;
                           row_d     = '0;
                           n_d       = n_q + StepN;
                        end else begin
                           cnt_row_d = cnt_row_q + One;
                           row_d     = row_q + StepRow;
                        end
                     end else begin
                        cnt_col_d = cnt_col_q + One;
                        col_d     = col_q + StepCol;
                     end
                  end else begin
                     cnt_m_d = cnt_m_q + One;
                     m_d     = m_q + StepM;
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Abort overrides any tile_done taken above. In idle it has no effect.
      if (bus.conv_abort && state_q != StIdle) begin
         state_d = StIdle;
         {n_d, m_d, row_d, col_d, idx_d} = '0;
         {cnt_m_d, cnt_col_d, cnt_row_d} = '0;
      end
      // The output flags follow the state being entered, so they are registered.
      start_d = (state_d == StStart);
      busy_d  = (state_d == StStart) || (state_d == StWait);
      done_d  = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         n_q       <= '0;
         m_q       <= '0;
         row_q     <= '0;
         col_q     <= '0;
         idx_q     <= '0;
         cnt_m_q   <= '0;
         cnt_col_q <= '0;
         cnt_row_q <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         m_q       <= m_d;
         row_q     <= row_d;
         col_q     <= col_d;
         idx_q     <= idx_d;
         cnt_m_q   <= cnt_m_d;
         cnt_col_q <= cnt_col_d;
         cnt_row_q <= cnt_row_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.conv_tile_start = start_q;
   assign bus.conv_busy       = busy_q;
   assign bus.conv_done       = done_q;
   assign bus.tile_base_n     = n_q;
   assign bus.tile_base_m     = m_q;
   assign bus.tile_base_row   = row_q;
   assign bus.tile_base_col   = col_q;
   assign bus.tile_idx        = idx_q;
endmodule
